// File: rtl/ms_ctrl_pkg.sv
// Shared state encoding and default timing constants for the ms counter run controller.
package ms_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_LAP,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam int DEF_TICK_DIV = 100000;
  localparam int DEF_MAX_MS   = 59999;

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler that divides CLK down to a 1 ms tick; holds its count while run is low.
module ms_tick_gen
  import ms_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int PS_W     = $clog2(TICK_DIV)
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps;

  assign tick = run && (ps == PS_LAST);

  // Holding while not running keeps the partial millisecond across a pause.
  always_ff @(posedge CLK) begin
    if (RST || zero) begin
      ps <= '0;
    end else if (run) begin
      ps <= tick ? '0 : ps + PS_W'(1);
    end
  end

endmodule

// File: rtl/ms_counter_ctrl.sv
// Run controller for the cascaded ms counter chain: start/stop/lap/clear sequencing,
// 1 ms enable pulses, elapsed tracking and stop-at-limit.
module ms_counter_ctrl
  import ms_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int MAX_MS   = DEF_MAX_MS,
  parameter int PS_W     = $clog2(TICK_DIV),
  parameter int EL_W     = $clog2(MAX_MS + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            btn_start_stop,
  input  logic            btn_clear,
  input  logic            btn_lap,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            lap_hold,
  output logic            running,
  output logic            overflow,
  output logic [EL_W-1:0] elapsed
);

  localparam logic [EL_W-1:0] EL_LAST = EL_W'(MAX_MS - 1);

  state_t state;
  state_t nxt;
  logic   run;
  logic   tick;

  assign run = (state == ST_RUN) || (state == ST_LAP);

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PS_W     (PS_W)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .run  (run),
    .zero (btn_clear),
    .tick (tick)
  );

  // Clear is handled in the register block; start_stop outranks lap here.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (btn_start_stop) nxt = ST_RUN;
      ST_RUN:   if (btn_start_stop) nxt = ST_PAUSE;
                else if (btn_lap)   nxt = ST_LAP;
      ST_LAP:   if (btn_start_stop) nxt = ST_PAUSE;
                else if (btn_lap)   nxt = ST_RUN;
      ST_PAUSE: if (btn_start_stop) nxt = ST_RUN;
      ST_DONE:  nxt = ST_DONE;
      default:  nxt = ST_IDLE;
    endcase
    // The limit tick is still issued, but the run ends on the same edge.
    if (tick && (elapsed == EL_LAST)) nxt = ST_DONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      elapsed  <= '0;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      lap_hold <= 1'b0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else if (btn_clear) begin
      state    <= ST_IDLE;
      elapsed  <= '0;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b1;
      lap_hold <= 1'b0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= nxt;
      cnt_en   <= tick;
      cnt_clr  <= 1'b0;
      if (tick) elapsed <= elapsed + EL_W'(1);
      lap_hold <= (nxt == ST_LAP);
      running  <= (nxt == ST_RUN) || (nxt == ST_LAP);
      overflow <= (nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_ms_counter_ctrl.sv
// Bench for ms_counter_ctrl: directed literal checks plus randomized pulses against a cycle-accounting model.
module tb_ms_counter_ctrl;

  localparam int TD = 4;
  localparam int MM = 5;
  localparam int EW = $clog2(MM + 1);

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_LAP   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ss  = 1'b0;
  logic          clr = 1'b0;
  logic          lap = 1'b0;
  logic          cnt_en, cnt_clr, lap_hold, running, overflow;
  logic [EW-1:0] elapsed;

  ms_counter_ctrl #(
    .TICK_DIV (TD),
    .MAX_MS   (MM)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .btn_start_stop (ss),
    .btn_clear      (clr),
    .btn_lap        (lap),
    .cnt_en         (cnt_en),
    .cnt_clr        (cnt_clr),
    .lap_hold       (lap_hold),
    .running        (running),
    .overflow       (overflow),
    .elapsed        (elapsed)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: elapsed is simply the number of counting cycles since clear divided by TD.
  int m_mode = M_IDLE;
  int m_cyc  = 0;
  int e_en = 0, e_clr = 0, e_lap = 0, e_run = 0, e_ovf = 0, e_el = 0;

  always @(posedge CLK) begin
    e_en  = 0;
    e_clr = 0;
    if (RST) begin
      m_mode = M_IDLE;
      m_cyc  = 0;
    end else if (clr) begin
      m_mode = M_IDLE;
      m_cyc  = 0;
      e_clr  = 1;
    end else begin
      if (m_mode == M_RUN || m_mode == M_LAP) begin
        m_cyc++;
        if (m_cyc % TD == 0) e_en = 1;
      end
      if (ss) begin
        if (m_mode == M_IDLE || m_mode == M_PAUSE) m_mode = M_RUN;
        else if (m_mode == M_RUN || m_mode == M_LAP) m_mode = M_PAUSE;
      end else if (lap) begin
        if (m_mode == M_RUN) m_mode = M_LAP;
        else if (m_mode == M_LAP) m_mode = M_RUN;
      end
      if (m_cyc >= MM * TD) m_mode = M_DONE;
    end
    e_el  = m_cyc / TD;
    e_lap = (m_mode == M_LAP) ? 1 : 0;
    e_run = (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0;
    e_ovf = (m_mode == M_DONE) ? 1 : 0;
  end

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("cnt_en",   int'(cnt_en),   e_en);
      chk("cnt_clr",  int'(cnt_clr),  e_clr);
      chk("lap_hold", int'(lap_hold), e_lap);
      chk("running",  int'(running),  e_run);
      chk("overflow", int'(overflow), e_ovf);
      chk("elapsed",  int'(elapsed),  e_el);
    end
  end

  task automatic step(input bit r, input bit s, input bit c, input bit l);
    @(negedge CLK);
    #1;
    RST = r;
    ss  = s;
    clr = c;
    lap = l;
  endtask

  initial begin
    int first;
    int seen;
    bit found;
    int en_at;

    @(posedge CLK);
    cmp_on = 1'b1;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_en",  int'(cnt_en), 0);
    chk("rst_clr", int'(cnt_clr), 0);
    chk("rst_run", int'(running), 0);
    chk("rst_el",  int'(elapsed), 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // Start: first tick 4 edges after the start edge, then every 4
    first = -1;
    for (int j = 1; j <= 9; j++) begin
      step(0, 0, 0, 0);
      if (j == 1) begin
        chk("start_running", int'(running), 1);
        chk("start_no_en", int'(cnt_en), 0);
      end
      if (cnt_en && first < 0) first = j;
      if (j == 5) chk("elapsed_1", int'(elapsed), 1);
      if (j == 9) chk("elapsed_2", int'(elapsed), 2);
    end
    chk("first_tick_step", first, 5);

    // Pause one cycle after a tick, idle, then resume
    step(0, 1, 0, 0);
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0);
      if (k == 1) chk("paused_running", int'(running), 0);
      if (cnt_en) seen++;
    end
    chk("pause_no_tick", seen, 0);
    step(0, 1, 0, 0);
    first = -1;
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0);
      if (cnt_en && first < 0) first = k;
    end
    chk("resume_tick_step", first, 3);
    chk("elapsed_3", int'(elapsed), 3);

    // Run to the limit
    found = 1'b0;
    en_at = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(0, 0, 0, 0);
      if (overflow) begin
        found = 1'b1;
        en_at = int'(cnt_en);
      end
    end
    chk("limit_reached", int'(found), 1);
    chk("limit_en", en_at, 1);
    chk("limit_elapsed", int'(elapsed), 5);
    chk("limit_running", int'(running), 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("done_holds", int'(overflow), 1);
    chk("done_elapsed", int'(elapsed), 5);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("clear_pulse", int'(cnt_clr), 1);
    chk("clear_elapsed", int'(elapsed), 0);
    chk("clear_ovf", int'(overflow), 0);
    step(0, 0, 0, 0);
    chk("clear_single", int'(cnt_clr), 0);

    // Lap then reset mid-run
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("lap_hold_on", int'(lap_hold), 1);
    chk("lap_running", int'(running), 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_lap_hold", int'(lap_hold), 0);
    chk("rst_mid_run", int'(running), 0);
    step(0, 1, 0, 0);
    first = -1;
    for (int j = 1; j <= 8; j++) begin
      step(0, 0, 0, 0);
      if (cnt_en && first < 0) first = j;
    end
    chk("restart_tick_step", first, 5);

    // Randomized pulses; coincidences exercise the priority rules
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 7) == 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
